conv_row_assembler: RTL and testbench
=====================================

// Module: conv_row_assembler
// PURPOSE
//  Upstream stage of the max-pooling row pair. Collects a pixel stream (one pixel of D channels per
//  accepted beat, raster order) into complete image rows of W pixels. Each finished row is presented
//  on a wide bus with a one-cycle valid pulse, directly driving the max-pooling block's row input/valid.
//  Tracks the row index within an H-row frame and flags frame completion.
// PARAMETERS
//  DATA_BITS  32  bits per channel value
//  D          1   channels per pixel
//  H          48  rows per frame
//  W          48  pixels per row (must be even, >=2)
// PORTS
//  clk        in   1                  clock, all logic on rising edge
//  reset      in   1                  synchronous, active-low reset (0 = reset)
//  pix_i      in   D*DATA_BITS        input pixel, channel k at bits [(k+1)*DATA_BITS-1 : k*DATA_BITS]
//  pix_valid  in   1                  pix_i valid this cycle
//  sof_i      in   1                  qualifies pix_valid: this pixel is row 0, column 0 of a new frame
//  row_o      out  W*D*DATA_BITS      assembled row; pixel c at bits [(c+1)*D*DATA_BITS-1 : c*D*DATA_BITS]
//  valid_o    out  1                  one-cycle pulse: row_o holds a new complete row
//  row_idx_o  out  clog2(H)           index (0..H-1) of the row currently on row_o
//  frame_done out  1                  pulses with valid_o when the row is row H-1
// BEHAVIOUR
//  - Reset (reset==0 at rising edge): row_o=0, valid_o=0, row_idx_o=0, frame_done=0, column counter=0,
//    row counter=0, assembly buffer=0; a partial row is discarded. Reset wins over any input that cycle.
//  - No backpressure: every cycle with pix_valid=1 accepts pix_i. Gaps (pix_valid=0) are allowed anywhere;
//    counters and buffers hold.
//  - Accepted pixel written to assembly buffer slot col; col increments. On accept with col==W-1:
//    assembly buffer (incl. this pixel) copied to row_o, col wraps to 0, valid_o=1 in the NEXT cycle
//    (latency 1 cycle from last pixel accept to valid_o), row_idx_o = row count of that row.
//  - Back-to-back rows: pixel 0 of the next row may be accepted in the same cycle valid_o is high;
//    row_o is unaffected until that next row completes (assembly buffer separate from row_o).
//  - valid_o is high exactly one cycle per completed row, never two consecutive cycles unless W==1 (illegal).
//  - Row counter increments on each completed row; on completing row H-1: frame_done=1 together with
//    valid_o, row counter wraps to 0.
//  - sof_i with pix_valid: forces col=0 and row counter=0 before the write (pixel stored at slot 0);
//    any partial row is dropped without a valid_o. sof_i at col==0,row==0 is a no-op resync.
//  - sof_i without pix_valid is ignored.
//  - row_o and row_idx_o hold between pulses; pooling stage relies on them only when valid_o=1.
// CONFIGURATION
//  ROWASM_ERR_EN defined: extra output err_o (1 bit), reset 0, sticky until reset. Set the cycle after
//    an accepted sof_i when col!=0 or row counter!=0 (truncated row/frame). Resync still occurs as above.
//  ROWASM_ERR_EN undefined: no err_o port, no detection logic; resync behaviour identical.
// TESTING  (W=4, H=4, D=1, DATA_BITS=8 unless stated)
//  1 reset=0 for 2 cycles then release -> row_o=0, valid_o=0, row_idx_o=0, frame_done=0.
//  2 sof on pixel 0x10, then 0x11,0x12,0x13 consecutive -> one cycle after 0x13: valid_o=1,
//    row_o=32'h13121110, row_idx_o=0; valid_o=0 next cycle.
//  3 16 consecutive pixels 0x00..0x0F with gaps of 0-3 idle cycles -> 4 valid_o pulses, row_idx 0..3,
//    last row_o=32'h0F0E0D0C with frame_done=1; 5th row reports row_idx_o=0.
//  4 send 0xA0,0xA1 then sof on 0xB0,+0xB1..0xB3 -> no pulse for partial row; one pulse row_o=32'hB3B2B1B0,
//    row_idx_o=0; with ROWASM_ERR_EN err_o=1 and stays 1.
//  5 assert reset=0 after 2 pixels of a row, release, send 4 pixels -> single pulse holding only the
//    post-reset pixels, row_idx_o=0.
//  6 W=48, D=1, DATA_BITS=32 connected to the max-pooling block, 2 rows -> pooling valid on 2nd row pulse,
//    24 outputs equal to 2x2 maxima of the driven data.

Source files
------------

// File: rtl/conv_row_assembler_if.sv
// rtl/conv_row_assembler_if.sv - pixel-in / row-out bus of the row assembler (err_o present with ROWASM_ERR_EN)
interface conv_row_assembler_if #(
  parameter int DATA_BITS = 32,
  parameter int D         = 1,
  parameter int H         = 48,
  parameter int W         = 48
);
  localparam int IW = (H > 1) ? $clog2(H) : 1;

  logic [D*DATA_BITS-1:0]   pix_i;
  logic                     pix_valid;
  logic                     sof_i;
  logic [W*D*DATA_BITS-1:0] row_o;
  logic                     valid_o;
  logic [IW-1:0]            row_idx_o;
  logic                     frame_done;
`ifdef ROWASM_ERR_EN
  logic                     err_o;
`endif

  modport master (
    output pix_i, pix_valid, sof_i,
`ifdef ROWASM_ERR_EN
    input  err_o,
`endif
    input  row_o, valid_o, row_idx_o, frame_done
  );

  modport slave (
    input  pix_i, pix_valid, sof_i,
`ifdef ROWASM_ERR_EN
    output err_o,
`endif
    output row_o, valid_o, row_idx_o, frame_done
  );
endinterface

// File: rtl/conv_row_assembler.sv
// rtl/conv_row_assembler.sv - collects a pixel stream into W-pixel rows with row/frame tracking
// Optional sticky truncation error output enabled by defining ROWASM_ERR_EN.
module conv_row_assembler #(
  parameter int DATA_BITS = 32,
  parameter int D         = 1,
  parameter int H         = 48,
  parameter int W         = 48
) (
  input  logic                clk,
  input  logic                reset,
  conv_row_assembler_if.slave bus
);
  localparam int PW = D * DATA_BITS;
  localparam int CW = $clog2(W);
  localparam int IW = (H > 1) ? $clog2(H) : 1;

  logic [CW-1:0]     col;
  logic [CW-1:0]     col_eff;
  logic [IW-1:0]     row_cnt;
  logic [IW-1:0]     row_eff;
  logic [W*PW-1:0]   asm_buf;
  logic [W*PW-1:0]   next_buf;
  logic              last_col;
  logic              last_row;

  // sof_i restarts the frame before the write, so the pixel lands in slot 0 of row 0
  always_comb begin
    col_eff  = bus.sof_i ? '0 : col;
    row_eff  = bus.sof_i ? '0 : row_cnt;
    next_buf = asm_buf;
    next_buf[col_eff*PW +: PW] = bus.pix_i;
    last_col = (col_eff == CW'(W - 1));
    last_row = (row_eff == IW'(H - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col            <= '0;
      row_cnt        <= '0;
      asm_buf        <= '0;
      bus.row_o      <= '0;
      bus.valid_o    <= 1'b0;
      bus.row_idx_o  <= '0;
      bus.frame_done <= 1'b0;
`ifdef ROWASM_ERR_EN
      bus.err_o      <= 1'b0;
`endif
    end else begin
      bus.valid_o    <= 1'b0;
      bus.frame_done <= 1'b0;
      if (bus.pix_valid) begin
        asm_buf <= next_buf;
`ifdef ROWASM_ERR_EN
        if (bus.sof_i && (col != '0 || row_cnt != '0))
          bus.err_o <= 1'b1;
`endif
        if (last_col) begin
          col            <= '0;
          bus.row_o      <= next_buf;
          bus.valid_o    <= 1'b1;
          bus.row_idx_o  <= row_eff;
          bus.frame_done <= last_row;
          row_cnt        <= last_row ? '0 : row_eff + 1'b1;
        end else begin
          col     <= col_eff + 1'b1;
          row_cnt <= row_eff;
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_row_assembler.sv
// tb/tb_conv_row_assembler.sv - directed table-driven bench for conv_row_assembler (W=4, H=4, D=1, 8-bit)
module tb_conv_row_assembler;
  localparam int DATA_BITS = 8;
  localparam int D = 1;
  localparam int H = 4;
  localparam int W = 4;

  typedef struct {
    logic        v;
    logic        s;
    logic [7:0]  pix;
    logic        ev;
    logic [31:0] er;
    logic [1:0]  ei;
    logic        ef;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   failed = 0;
  vec_t vecs[$];
  logic [31:0] hold_row;
  logic [1:0]  hold_idx;

  always #5 clk = ~clk;

  conv_row_assembler_if #(.DATA_BITS(DATA_BITS), .D(D), .H(H), .W(W)) bus ();

  conv_row_assembler #(.DATA_BITS(DATA_BITS), .D(D), .H(H), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic v, input logic s, input logic [7:0] p, input logic ev,
                              input logic [31:0] er, input logic [1:0] ei, input logic ef);
    vec_t t;
    t.v = v; t.s = s; t.pix = p; t.ev = ev; t.er = er; t.ei = ei; t.ef = ef;
    vecs.push_back(t);
  endfunction

  task automatic step(input logic v, input logic s, input logic [7:0] p);
    bus.pix_valid = v;
    bus.sof_i     = s;
    bus.pix_i     = p;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic ev, input logic [31:0] er,
                           input logic [1:0] ei, input logic ef);
    check({name, ".valid"}, 64'(bus.valid_o), 64'(ev));
    check({name, ".row"}, 64'(bus.row_o), 64'(er));
    check({name, ".idx"}, 64'(bus.row_idx_o), 64'(ei));
    check({name, ".fdone"}, 64'(bus.frame_done), 64'(ef));
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.sof_i     = 1'b0;
    bus.pix_i     = '0;

    // single row with an ignored idle-cycle sof in the middle
    add(1, 1, 8'h10, 0, 0, 0, 0);
    add(1, 0, 8'h11, 0, 0, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0, 0);
    add(1, 0, 8'h12, 0, 0, 0, 0);
    add(1, 0, 8'h13, 1, 32'h13121110, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 0);
    // full frame plus one row, idle gaps of (p+1)%4 so rows complete back-to-back
    for (int p = 0; p < 20; p++) begin
      logic [7:0] b;
      b = 8'(p);
      add(1, p == 0, b, (p % 4) == 3,
          {b, b - 8'd1, b - 8'd2, b - 8'd3}, 2'((p / 4) % 4),
          ((p % 4) == 3) && (((p / 4) % 4) == 3));
      for (int g = 0; g < (p + 1) % 4; g++)
        add(0, 0, 8'h00, 0, 0, 0, 0);
    end

    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 0, 0);
`ifdef ROWASM_ERR_EN
    check("reset.err", 64'(bus.err_o), 64'd0);
`endif
    reset = 1'b1;
    hold_row = '0;
    hold_idx = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      string nm;
      step(vecs[i].v, vecs[i].s, vecs[i].pix);
      if (vecs[i].ev) begin
        hold_row = vecs[i].er;
        hold_idx = vecs[i].ei;
      end
      nm = $sformatf("vec%0d", i);
      check_out(nm, vecs[i].ev, hold_row, hold_idx, vecs[i].ef);
`ifdef ROWASM_ERR_EN
      if (i == 5) check("row_only.err", 64'(bus.err_o), 64'd0);
`endif
    end

    // partial row dropped by sof
    step(1, 0, 8'hA0);
    step(1, 0, 8'hA1);
    check("trunc.nopulse", 64'(bus.valid_o), 64'd0);
    step(1, 1, 8'hB0);
    check("trunc.nopulse2", 64'(bus.valid_o), 64'd0);
    step(1, 0, 8'hB1);
    step(1, 0, 8'hB2);
    step(1, 0, 8'hB3);
    check_out("trunc", 1, 32'hB3B2B1B0, 0, 0);
    step(0, 0, 8'h00);
    check("trunc.pulse_end", 64'(bus.valid_o), 64'd0);
`ifdef ROWASM_ERR_EN
    check("trunc.err", 64'(bus.err_o), 64'd1);
`endif

    // reset in the middle of a row
    step(1, 0, 8'h21);
    step(1, 0, 8'h22);
    reset = 1'b0;
    step(1, 0, 8'h23);
    check_out("midreset", 0, 0, 0, 0);
`ifdef ROWASM_ERR_EN
    check("midreset.err", 64'(bus.err_o), 64'd0);
`endif
    reset = 1'b1;
    step(1, 0, 8'h31);
    step(1, 0, 8'h32);
    step(1, 0, 8'h33);
    check("midreset.nopulse", 64'(bus.valid_o), 64'd0);
    step(1, 0, 8'h34);
    check_out("postreset", 1, 32'h34333231, 0, 0);
    step(0, 0, 8'h00);
    check("postreset.pulse_end", 64'(bus.valid_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
